field_limit_counter: RTL and testbench

Parametrised bank of per-field edit counters for the date/time/timer setting path. It holds N_FIELDS values, each wrapping at its own upper limit, and keeps a cursor selecting the field under edit. Increment, decrement and direct-load requests update the fields, and the block reports the selected field's value and limit. It sits between the button/debounce front end and the RTC write sequencer, and replaces the stand-alone combinational limit decode with a registered, generalised edit engine.

---
 rtl/field_counter_pkg.sv | 29 ++
 rtl/field_limit_rom.sv | 14 +
 rtl/field_limit_counter.sv | 104 ++++++++++
 tb/tb_field_limit_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/field_counter_pkg.sv
// Shared definitions for the per-field edit counters: default sizing,
// the per-field wrap limits and the symbolic field indices.
package field_counter_pkg;

  localparam int DEF_N_FIELDS = 9;
  localparam int DEF_W        = 7;
  localparam int N_TABLE      = 9;

  localparam int LIMIT_TABLE [N_TABLE] = '{23, 59, 59, 30, 11, 99, 23, 59, 59};

  typedef enum int {
    F_HOUR   = 0,
    F_MIN    = 1,
    F_SEC    = 2,
    F_DAY    = 3,
    F_MONTH  = 4,
    F_YEAR   = 5,
    F_T_HOUR = 6,
    F_T_MIN  = 7,
    F_T_SEC  = 8
  } field_idx_e;

  // Fields beyond the table are free-running over the full value width.
  function automatic int limit_of(input int idx, input int w);
    if (idx < N_TABLE) return LIMIT_TABLE[idx];
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/field_limit_rom.sv
// Combinational field index to upper-limit decode.
module field_limit_rom
  import field_counter_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = 4
) (
  input  logic [CW-1:0] i_idx,
  output logic [W-1:0]  o_limit
);

  always_comb o_limit = W'(limit_of(int'(i_idx), W));

endmodule

// File: rtl/field_limit_counter.sv
// Bank of wrapping per-field edit counters with a cursor, direct load and a
// registered write-strobe; outputs follow registered state one edge after a request.
module field_limit_counter
  import field_counter_pkg::*;
#(
  parameter int  N_FIELDS = DEF_N_FIELDS,
  parameter int  W        = DEF_W,
  localparam int CW       = $clog2(N_FIELDS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  down,
  input  logic                  next,
  input  logic                  prev,
  input  logic                  load,
  input  logic [CW-1:0]         load_idx,
  input  logic [W-1:0]          load_val,
  output logic [CW-1:0]         cursor,
  output logic [W-1:0]          cur_value,
  output logic [W-1:0]          cur_limit,
  output logic [N_FIELDS*W-1:0] values,
  output logic                  changed
);

  for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_lim_chk
    if (limit_of(gi, W) > (1 << W) - 1) begin : g_bad
      $error("field %0d limit does not fit in W bits", gi);
    end
  end

  logic [W-1:0]  r_values [N_FIELDS];
  logic [CW-1:0] r_cursor;
  logic          r_changed;

  logic [W-1:0]  w_cur_value;
  logic [W-1:0]  w_cur_limit;
  logic [W-1:0]  w_load_limit;
  logic [W-1:0]  w_load_clamped;
  logic [W-1:0]  w_edit_value;
  logic [CW-1:0] w_cursor_nxt;
  logic          w_edit;
  logic          w_move;
  logic          w_load_ok;

  field_limit_rom #(.W(W), .CW(CW)) u_rom_cursor (
    .i_idx   (r_cursor),
    .o_limit (w_cur_limit)
  );

  field_limit_rom #(.W(W), .CW(CW)) u_rom_load (
    .i_idx   (load_idx),
    .o_limit (w_load_limit)
  );

  assign w_cur_value    = r_values[r_cursor];
  assign w_edit         = en & (up ^ down);
  assign w_move         = en & (next ^ prev);
  assign w_load_ok      = load & ({1'b0, load_idx} < (CW+1)'(N_FIELDS));
  assign w_load_clamped = (load_val > w_load_limit) ? w_load_limit : load_val;

  always_comb begin
    w_edit_value = w_cur_value;
    if (up) begin
      w_edit_value = (w_cur_value == w_cur_limit) ? '0 : w_cur_value + 1'b1;
    end else begin
      w_edit_value = (w_cur_value == '0) ? w_cur_limit : w_cur_value - 1'b1;
    end
  end

  always_comb begin
    w_cursor_nxt = r_cursor;
    if (next) begin
      w_cursor_nxt = (r_cursor == CW'(N_FIELDS - 1)) ? '0 : r_cursor + 1'b1;
    end else begin
      w_cursor_nxt = (r_cursor == '0) ? CW'(N_FIELDS - 1) : r_cursor - 1'b1;
    end
  end

  // The load write follows the edit write so a same-field load takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_FIELDS; i++) r_values[i] <= '0;
      r_cursor  <= '0;
      r_changed <= 1'b0;
    end else begin
      if (w_edit)    r_values[r_cursor] <= w_edit_value;
      if (w_load_ok) r_values[load_idx] <= w_load_clamped;
      if (w_move)    r_cursor <= w_cursor_nxt;
      r_changed <= w_edit | w_load_ok;
    end
  end

  for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_pack
    assign values[gi*W +: W] = r_values[gi];
  end

  assign cursor    = r_cursor;
  assign cur_value = w_cur_value;
  assign cur_limit = en ? w_cur_limit : '0;
  assign changed   = r_changed;

endmodule

// File: tb/tb_field_limit_counter.sv
// Scoreboard bench for field_limit_counter: a behavioural model pushes the
// expected post-edge state for each driven cycle, popped and compared after the edge.
module tb_field_limit_counter;

  localparam int NF = 9;
  localparam int W  = 7;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0, up = 1'b0, down = 1'b0, next = 1'b0, prev = 1'b0, load = 1'b0;
  logic [CW-1:0] load_idx = '0;
  logic [W-1:0]  load_val = '0;
  logic [CW-1:0] cursor;
  logic [W-1:0]  cur_value;
  logic [W-1:0]  cur_limit;
  logic [NF*W-1:0] values;
  logic          changed;

  field_limit_counter #(.N_FIELDS(NF), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .down(down),
    .next(next), .prev(prev), .load(load), .load_idx(load_idx),
    .load_val(load_val), .cursor(cursor), .cur_value(cur_value),
    .cur_limit(cur_limit), .values(values), .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cur;
    int          val;
    int          lim;
    logic [63:0] vals;
    int          chg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   lim_tbl [NF] = '{23, 59, 59, 30, 11, 99, 23, 59, 59};
  int   m_val [NF];
  int   m_cur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] p = '0;
    for (int i = 0; i < NF; i++) p[i*W +: W] = W'(m_val[i]);
    return p;
  endfunction

  task automatic step(input string tag, input logic e, input logic u, input logic d,
                      input logic n, input logic p, input logic l, input int li, input int lv);
    exp_t x;
    int   c0;
    bit   wr;
    en = e; up = u; down = d; next = n; prev = p; load = l;
    load_idx = CW'(li); load_val = W'(lv);
    c0 = m_cur;
    wr = 0;
    if (e && (u != d)) begin
      if (u) m_val[c0] = (m_val[c0] >= lim_tbl[c0]) ? 0 : m_val[c0] + 1;
      else   m_val[c0] = (m_val[c0] == 0) ? lim_tbl[c0] : m_val[c0] - 1;
      wr = 1;
    end
    if (l && li < NF) begin
      m_val[li] = (lv < lim_tbl[li]) ? lv : lim_tbl[li];
      wr = 1;
    end
    if (e && n && !p) m_cur = (c0 + 1) % NF;
    if (e && p && !n) m_cur = (c0 + NF - 1) % NF;
    x.cur = m_cur; x.val = m_val[m_cur]; x.lim = e ? lim_tbl[m_cur] : 0;
    x.vals = pack_model(); x.chg = wr ? 1 : 0;
    q.push_back(x);
    @(posedge clk);
    #1;
    up = 0; down = 0; next = 0; prev = 0; load = 0;
    if (q.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      x = q.pop_front();
      chk({tag, ".cursor"},  64'(cursor),    64'(x.cur));
      chk({tag, ".value"},   64'(cur_value), 64'(x.val));
      chk({tag, ".limit"},   64'(cur_limit), 64'(x.lim));
      chk({tag, ".values"},  64'(values),    x.vals);
      chk({tag, ".changed"}, 64'(changed),   64'(x.chg));
    end
  endtask

  task automatic idle(input string tag);
    step(tag, en, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NF; i++) m_val[i] = 0;
    m_cur = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    en = 1'b1;
    #1;
    chk("rst.cursor",  64'(cursor),    64'd0);
    chk("rst.value",   64'(cur_value), 64'd0);
    chk("rst.limit",   64'(cur_limit), 64'd23);
    chk("rst.changed", 64'(changed),   64'd0);
    chk("rst.values",  64'(values),    64'd0);

    step("ld23",   1, 0, 0, 0, 0, 1, 0, 23);
    step("up_wrap", 1, 1, 0, 0, 0, 0, 0, 0);
    chk("up_wrap.zero", 64'(cur_value), 64'd0);
    step("dn_wrap", 1, 0, 1, 0, 0, 0, 0, 0);
    chk("dn_wrap.lim", 64'(cur_value), 64'd23);
    step("updn",   1, 1, 1, 0, 0, 0, 0, 0);
    idle("idle0");

    for (int i = 0; i < 8; i++) step("nx", 1, 0, 0, 1, 0, 0, 0, 0);
    chk("at8", 64'(cursor), 64'd8);
    step("nx_wrap", 1, 0, 0, 1, 0, 0, 0, 0);
    chk("nx_wrap.zero", 64'(cursor), 64'd0);
    step("pv_wrap", 1, 0, 0, 0, 1, 0, 0, 0);
    chk("pv_wrap.eight", 64'(cursor), 64'd8);
    step("nxpv",   1, 0, 0, 1, 1, 0, 0, 0);

    step("ld_clamp", 1, 0, 0, 0, 0, 1, 3, 45);
    chk("ld_clamp.f3", 64'(values[3*W +: W]), 64'd30);
    step("ld_oob", 1, 0, 0, 0, 0, 1, 12, 5);
    chk("ld_oob.nochg", 64'(changed), 64'd0);

    step("to0", 1, 0, 0, 1, 0, 0, 0, 0);
    step("to1", 1, 0, 0, 1, 0, 0, 0, 0);
    step("ld10", 1, 0, 0, 0, 0, 1, 1, 10);
    step("up_ld_same", 1, 1, 0, 0, 0, 1, 1, 5);
    chk("up_ld_same.f1", 64'(values[1*W +: W]), 64'd5);
    step("ld10b", 1, 0, 0, 0, 0, 1, 1, 10);
    step("up_ld_diff", 1, 1, 0, 0, 0, 1, 2, 7);
    chk("up_ld_diff.f1", 64'(values[1*W +: W]), 64'd11);
    chk("up_ld_diff.f2", 64'(values[2*W +: W]), 64'd7);
    step("edit_move", 1, 0, 1, 1, 0, 0, 0, 0);

    step("dis_up", 0, 1, 0, 0, 0, 0, 0, 0);
    step("dis_nx", 0, 0, 0, 1, 0, 0, 0, 0);
    step("dis_ld", 0, 0, 0, 0, 0, 1, 5, 120);

    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 127)));
    end

    en = 1'b1; up = 1'b1; next = 1'b1; load = 1'b1; load_idx = 4'd4; load_val = 7'd9;
    #2 reset_n = 1'b0;
    #1;
    chk("arst.cursor",  64'(cursor),  64'd0);
    chk("arst.values",  64'(values),  64'd0);
    chk("arst.changed", 64'(changed), 64'd0);
    up = 0; next = 0; load = 0;
    for (int i = 0; i < NF; i++) m_val[i] = 0;
    m_cur = 0;
    @(negedge clk);
    reset_n = 1'b1;
    idle("post_rst");
    step("post_rst_up", 1, 1, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
